// File: rtl/register_file_wb_if.sv
// Writeback/decode bundle of the RV32I integer register file: writeback commit
// signals, decode read-port indices and operands, and the a0 debug mirror.
interface register_file_wb_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  RegWriteW;
  logic [ADDR_WIDTH-1:0] RdW;
  logic [WIDTH-1:0]      ResultW;
  logic [ADDR_WIDTH-1:0] Rs1D;
  logic [ADDR_WIDTH-1:0] Rs2D;
  logic [WIDTH-1:0]      RD1D;
  logic [WIDTH-1:0]      RD2D;
  logic [WIDTH-1:0]      a0;

  modport master (
    output RegWriteW, RdW, ResultW, Rs1D, Rs2D,
    input  RD1D, RD2D, a0
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, Rs1D, Rs2D,
    output RD1D, RD2D, a0
  );
endinterface

// File: rtl/register_file_wb.sv
// RV32I integer register file: one synchronous write port from writeback, two
// combinational decode read ports with write-through bypass, registered a0 mirror.
module register_file_wb #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEBUG_REG  = 10
) (
  input logic               clk,
  input logic               rst,
  register_file_wb_if.slave bus
);
  localparam int                    DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DBG_IDX = ADDR_WIDTH'(DEBUG_REG);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] dbg_p1;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             byp_en;
  logic             wr_en;

  assign byp_en = bus.RegWriteW && !rst;
  assign wr_en  = byp_en && (bus.RdW != '0);

  // commit stage: architectural state and the a0 mirror update together
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      dbg_p1 <= '0;
    end else if (wr_en) begin
      regs[bus.RdW] <= bus.ResultW;
      if (bus.RdW == DBG_IDX) dbg_p1 <= bus.ResultW;
    end
  end

  always_comb begin
    rd1 = regs[bus.Rs1D];
    if (bus.Rs1D == '0) rd1 = '0;
    else if (byp_en && (bus.RdW == bus.Rs1D)) rd1 = bus.ResultW;
  end

  always_comb begin
    rd2 = regs[bus.Rs2D];
    if (bus.Rs2D == '0) rd2 = '0;
    else if (byp_en && (bus.RdW == bus.Rs2D)) rd2 = bus.ResultW;
  end

  assign bus.RD1D = rd1;
  assign bus.RD2D = rd2;
  assign bus.a0   = dbg_p1;
endmodule

// File: tb/tb_register_file_wb.sv
// Bench for register_file_wb: directed vector table, a reset-collision sequence,
// and randomized traffic checked against an array-based reference model.
module tb_register_file_wb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  register_file_wb_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file_wb #(.WIDTH(32), .ADDR_WIDTH(5), .DEBUG_REG(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] model [32];
  logic [31:0] model_a0;

  typedef struct {
    logic        r;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_a0;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] model_read(input logic r, input logic we, input logic [4:0] rd,
                                             input logic [31:0] res, input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (!r && we && rd == rs) return res;
    return model[rs];
  endfunction

  // Applies one cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic r, input logic we, input logic [4:0] rd, input logic [31:0] res,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      output logic [31:0] got_rd1, output logic [31:0] got_rd2,
                      output logic [31:0] exp_rd1, output logic [31:0] exp_rd2,
                      output logic [31:0] got_a0);
    rst           = r;
    bus.RegWriteW = we;
    bus.RdW       = rd;
    bus.ResultW   = res;
    bus.Rs1D      = rs1;
    bus.Rs2D      = rs2;
    #2;
    got_rd1 = bus.RD1D;
    got_rd2 = bus.RD2D;
    exp_rd1 = model_read(r, we, rd, res, rs1);
    exp_rd2 = model_read(r, we, rd, res, rs2);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model_a0 = 32'd0;
    end else if (we && rd != 5'd0) begin
      model[rd] = res;
      if (rd == 5'd10) model_a0 = res;
    end
    #1;
    got_a0 = bus.a0;
  endtask

  logic [31:0] g1, g2, x1, x2, ga0;
  logic [4:0]  rrd, rr1, rr2;
  logic        rwe, rr;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd3,  32'hDEADBEEF, 5'd3,  5'd4,  32'hDEADBEEF, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 1'b0, 5'd3,  32'h0,        5'd3,  5'd4,  32'hDEADBEEF, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    vecs[4]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd3,  32'h0,        32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 5'd7,  32'h11,       5'd7,  5'd7,  32'h11,       32'h11,       32'h0};
    vecs[6]  = '{1'b0, 1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  32'h22,       32'h22,       32'h0};
    vecs[7]  = '{1'b0, 1'b0, 5'd7,  32'h33,       5'd7,  5'd7,  32'h22,       32'h22,       32'h0};
    vecs[8]  = '{1'b0, 1'b1, 5'd10, 32'h5,        5'd10, 5'd11, 32'h5,        32'h0,        32'h5};
    vecs[9]  = '{1'b0, 1'b1, 5'd11, 32'h9,        5'd10, 5'd11, 32'h5,        32'h9,        32'h5};
    vecs[10] = '{1'b0, 1'b0, 5'd11, 32'h0,        5'd10, 5'd11, 32'h5,        32'h9,        32'h5};
    vecs[11] = '{1'b1, 1'b1, 5'd10, 32'hABCD,     5'd10, 5'd11, 32'h5,        32'h9,        32'h0};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd10, 5'd11, 32'h0,        32'h0,        32'h0};
    vecs[13] = '{1'b0, 1'b1, 5'd10, 32'hABCD,     5'd10, 5'd3,  32'hABCD,     32'h0,        32'hABCD};
    vecs[14] = '{1'b0, 1'b0, 'x,    'x,           5'd10, 5'd0,  32'hABCD,     32'h0,        32'hABCD};
    vecs[15] = '{1'b0, 1'b1, 5'd31, 32'h80000000, 5'd31, 5'd31, 32'h80000000, 32'h80000000, 32'hABCD};

    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model_a0 = 32'd0;
    rst = 1'b1;
    bus.RegWriteW = 1'b0;
    bus.RdW = '0;
    bus.ResultW = '0;
    bus.Rs1D = '0;
    bus.Rs2D = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, g1, g2, x1, x2, ga0);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].r, vecs[i].we, vecs[i].rd, vecs[i].res, vecs[i].rs1, vecs[i].rs2,
           g1, g2, x1, x2, ga0);
      check($sformatf("vec%0d_rd1", i), g1, vecs[i].e_rd1);
      check($sformatf("vec%0d_rd2", i), g2, vecs[i].e_rd2);
      check($sformatf("vec%0d_a0", i), ga0, vecs[i].e_a0);
    end

    // reset collision, then the same write re-presented and read back through storage
    step(1'b1, 1'b1, 5'd10, 32'h1234, 5'd10, 5'd31, g1, g2, x1, x2, ga0);
    check("coll_rd1_stored", g1, 32'hABCD);
    check("coll_a0_cleared", ga0, 32'h0);
    step(1'b0, 1'b1, 5'd10, 32'h1234, 5'd31, 5'd10, g1, g2, x1, x2, ga0);
    check("replay_rd1_cleared", g1, 32'h0);
    check("replay_rd2_bypass", g2, 32'h1234);
    check("replay_a0", ga0, 32'h1234);
    step(1'b0, 1'b0, 5'd10, 32'h0, 5'd10, 5'd31, g1, g2, x1, x2, ga0);
    check("replay_rd1_stored", g1, 32'h1234);
    check("replay_a0_held", ga0, 32'h1234);

    for (int i = 0; i < 400; i++) begin
      rr  = ($urandom_range(0, 49) == 0);
      rwe = $urandom_range(0, 3) != 0;
      rrd = ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 31));
      rr1 = ($urandom_range(0, 2) == 0) ? rrd : 5'($urandom_range(0, 31));
      rr2 = ($urandom_range(0, 2) == 0) ? rrd : 5'($urandom_range(0, 31));
      step(rr, rwe, rrd, $urandom, rr1, rr2, g1, g2, x1, x2, ga0);
      check($sformatf("rnd%0d_rd1", i), g1, x1);
      check($sformatf("rnd%0d_rd2", i), g2, x2);
      check($sformatf("rnd%0d_a0", i), ga0, model_a0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
